// File: rtl/fifo_word_serializer_if.sv
// Read-side FIFO control plus narrow valid/ready beat stream used by fifo_word_serializer.
// master = the serializer; slave = the FIFO / downstream consumer side.
interface fifo_word_serializer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_cs;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [OUT_WIDTH-1:0]  m_data;
  logic                  m_last;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  m_ready,
    output fifo_cs,
    output fifo_rd_en,
    output m_valid,
    output m_data,
    output m_last
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output m_ready,
    input  fifo_cs,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data,
    input  m_last
  );
endinterface

// File: rtl/fifo_word_serializer.sv
// Drains words from a SyncFIFO (one-cycle registered read latency) and emits them as
// DATA_WIDTH/OUT_WIDTH narrow beats, least-significant beat first, on a valid/ready stream.
module fifo_word_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  fifo_word_serializer_if.master bus,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   word_cnt
);

  localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  if (DATA_WIDTH % OUT_WIDTH != 0) begin : g_width_check
    $error("fifo_word_serializer: DATA_WIDTH must be a multiple of OUT_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPTURE,
    SEND
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         beat_q,  beat_d;
  logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;
  logic                  rd_q,    rd_d;
  logic                  valid_q, valid_d;
  logic                  last_q,  last_d;
  logic                  busy_q,  busy_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (en && !bus.fifo_empty) state_d = READ;
      end
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // fifo_data is valid during this cycle because the read was issued in READ
        shift_d = bus.fifo_data;
        beat_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        if (bus.m_ready) begin
          if (beat_q == LAST_BEAT) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (en && !bus.fifo_empty) ? READ : IDLE;
          end else begin
            shift_d = shift_q >> OUT_WIDTH;
            beat_d  = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Moore outputs are registered by decoding the next state
    rd_d    = (state_d == READ);
    valid_d = (state_d == SEND);
    last_d  = (state_d == SEND) && (beat_d == LAST_BEAT);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.fifo_cs    = rd_q;
  assign bus.fifo_rd_en = rd_q;
  assign bus.m_valid    = valid_q;
  assign bus.m_data     = shift_q[OUT_WIDTH-1:0];
  assign bus.m_last     = last_q;
  assign busy           = busy_q;
  assign word_cnt       = cnt_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Bench for fifo_word_serializer: behavioural SyncFIFO, stream monitor, directed table,
// multi-cycle corner sequences and a randomized run against a word-to-beat reference.
module tb_fifo_word_serializer;
  localparam int DW = 32;
  localparam int OW = 8;
  localparam int CW = 16;
  localparam int BEATS = DW / OW;
  localparam int NW = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          busy;
  logic [CW-1:0] word_cnt;

  fifo_word_serializer_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus ();

  fifo_word_serializer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bus      (bus.master),
    .busy     (busy),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  // SyncFIFO model: samples cs & rd_en at the edge, data valid the following cycle
  logic [DW-1:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (bus.fifo_cs && bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
      bus.fifo_data <= mem[rd_ptr % 1024];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Monitor: samples at the falling edge, records what the next rising edge will do
  int cyc = 0;
  int n_rd = 0;
  int rd_empty_err = 0;
  int stall_err = 0;
  int busy_cyc = 0;
  logic [OW-1:0] got_d [$];
  logic          got_l [$];
  int rd_cyc [$];
  int rise_cyc [$];
  int last_cyc [$];
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic [OW-1:0] pd = '0;
  logic pl = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fifo_rd_en) begin
        n_rd++;
        rd_cyc.push_back(cyc);
        if (bus.fifo_empty) rd_empty_err++;
      end
      if (busy) busy_cyc++;
      if (bus.m_valid && !pv) rise_cyc.push_back(cyc);
      if (pv && !pr && (!bus.m_valid || bus.m_data != pd || bus.m_last != pl)) stall_err++;
      if (bus.m_valid && bus.m_ready) begin
        got_d.push_back(bus.m_data);
        got_l.push_back(bus.m_last);
        if (bus.m_last) last_cyc.push_back(cyc);
      end
    end
    pv = bus.m_valid && !rst;
    pr = bus.m_ready;
    pd = bus.m_data;
    pl = bus.m_last;
    cyc++;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [CW-1:0] cnt_model = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr % 1024] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_beats(input string name, input int target, input int budget);
    int k;
    k = 0;
    while (got_d.size() < target && k < budget) begin
      step(1);
      k++;
    end
    check(name, 64'(got_d.size() >= target), 64'd1);
  endtask

  typedef struct {
    logic [DW-1:0] word;
    int            stall_at;
    int            stall_len;
    logic [OW-1:0] beats [BEATS];
  } vec_t;

  vec_t vecs [5];

  task automatic set_vec(input int i, input logic [DW-1:0] w, input int sa, input int sl,
                         input logic [OW-1:0] b0, input logic [OW-1:0] b1,
                         input logic [OW-1:0] b2, input logic [OW-1:0] b3);
    vecs[i].word = w;
    vecs[i].stall_at = sa;
    vecs[i].stall_len = sl;
    vecs[i].beats[0] = b0;
    vecs[i].beats[1] = b1;
    vecs[i].beats[2] = b2;
    vecs[i].beats[3] = b3;
  endtask

  initial begin
    int base_g, base_rd, base_rise, base_rc, base_lc, base_st, base_busy, rem, k;
    logic [DW-1:0] wq [$];
    logic [DW-1:0] w;
    logic [OW-1:0] tb_beats [12];

    set_vec(0, 32'h11223344, -1, 0, 8'h44, 8'h33, 8'h22, 8'h11);
    set_vec(1, 32'h11223344,  1, 3, 8'h44, 8'h33, 8'h22, 8'h11);
    set_vec(2, 32'hA5A50F0F,  3, 2, 8'h0F, 8'h0F, 8'hA5, 8'hA5);
    set_vec(3, 32'hFFFFFFFF,  0, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    set_vec(4, 32'h80000001, -1, 0, 8'h01, 8'h00, 8'h00, 8'h80);

    // Reset with random inputs
    bus.m_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      en = 1'($urandom_range(0, 1));
      bus.m_ready = 1'($urandom_range(0, 1));
      step(1);
      check("rst_m_valid", 64'(bus.m_valid), 64'd0);
      check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
      check("rst_cs", 64'(bus.fifo_cs), 64'd0);
      check("rst_m_last", 64'(bus.m_last), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_word_cnt", 64'(word_cnt), 64'd0);
    end
    rst = 1'b0;
    en = 1'b0;
    bus.m_ready = 1'b1;
    step(2);

    // Table of single words, some with backpressure on one beat
    for (int v = 0; v < 5; v++) begin
      base_g = got_d.size();
      base_rd = n_rd;
      base_rise = rise_cyc.size();
      base_rc = rd_cyc.size();
      base_st = stall_err;
      rem = vecs[v].stall_len;
      en = 1'b1;
      bus.m_ready = 1'b1;
      push(vecs[v].word);
      k = 0;
      while (got_d.size() < base_g + BEATS && k < 60) begin
        if (bus.m_valid && (got_d.size() - base_g) == vecs[v].stall_at && rem > 0) begin
          bus.m_ready = 1'b0;
          rem--;
          check("bp_data", 64'(bus.m_data), 64'(vecs[v].beats[vecs[v].stall_at]));
        end else begin
          bus.m_ready = 1'b1;
        end
        step(1);
        k++;
      end
      bus.m_ready = 1'b1;
      check("vec_timeout", 64'(got_d.size() >= base_g + BEATS), 64'd1);
      step(3);
      for (int i = 0; i < BEATS; i++) begin
        check("vec_beat", 64'(got_d[base_g + i]), 64'(vecs[v].beats[i]));
        check("vec_last", 64'(got_l[base_g + i]), 64'(i == BEATS - 1));
      end
      cnt_model = cnt_model + 1'b1;
      check("vec_rd_pulses", 64'(n_rd - base_rd), 64'd1);
      if (rise_cyc.size() > base_rise && rd_cyc.size() > base_rc)
        check("vec_latency", 64'(rise_cyc[base_rise] - rd_cyc[base_rc]), 64'd2);
      else
        check("vec_latency_seen", 64'd0, 64'd1);
      check("vec_stall_hold", 64'(stall_err - base_st), 64'd0);
      check("vec_word_cnt", 64'(word_cnt), 64'(cnt_model));
      check("vec_idle", 64'(busy), 64'd0);
    end

    // Back-to-back: 1, 2, 4
    en = 1'b0;
    step(1);
    base_g = got_d.size();
    base_rd = n_rd;
    base_rc = rd_cyc.size();
    base_lc = last_cyc.size();
    push(32'd1);
    push(32'd2);
    push(32'd4);
    en = 1'b1;
    wait_beats("b2b_timeout", base_g + 12, 100);
    step(4);
    for (int i = 0; i < 12; i++) tb_beats[i] = 8'h00;
    tb_beats[0] = 8'h01;
    tb_beats[4] = 8'h02;
    tb_beats[8] = 8'h04;
    for (int i = 0; i < 12; i++) begin
      check("b2b_beat", 64'(got_d[base_g + i]), 64'(tb_beats[i]));
      check("b2b_last", 64'(got_l[base_g + i]), 64'((i % 4) == 3));
    end
    check("b2b_rd_pulses", 64'(n_rd - base_rd), 64'd3);
    if (rd_cyc.size() >= base_rc + 3 && last_cyc.size() >= base_lc + 2) begin
      check("b2b_no_gap0", 64'(rd_cyc[base_rc + 1] - last_cyc[base_lc]), 64'd1);
      check("b2b_no_gap1", 64'(rd_cyc[base_rc + 2] - last_cyc[base_lc + 1]), 64'd1);
    end else begin
      check("b2b_events_seen", 64'd0, 64'd1);
    end
    cnt_model = cnt_model + 3'd3;
    check("b2b_word_cnt", 64'(word_cnt), 64'(cnt_model));
    check("b2b_idle", 64'(busy), 64'd0);

    // Empty with en=1, then en=0 with a non-empty FIFO
    base_rd = n_rd;
    base_busy = busy_cyc;
    en = 1'b1;
    step(20);
    en = 1'b0;
    push(32'hCAFEBABE);
    push(32'hDEADBEEF);
    step(10);
    check("empty_no_rd", 64'(n_rd - base_rd), 64'd0);
    check("empty_no_busy", 64'(busy_cyc - base_busy), 64'd0);
    check("rd_while_empty", 64'(rd_empty_err), 64'd0);

    // Drop en after 2 beats: word finishes, no further read
    base_g = got_d.size();
    base_rd = n_rd;
    en = 1'b1;
    wait_beats("den_timeout2", base_g + 2, 40);
    en = 1'b0;
    step(12);
    check("den_beats", 64'(got_d.size() - base_g), 64'd4);
    check("den_b0", 64'(got_d[base_g + 0]), 64'hBE);
    check("den_b1", 64'(got_d[base_g + 1]), 64'hBA);
    check("den_b2", 64'(got_d[base_g + 2]), 64'hFE);
    check("den_b3", 64'(got_d[base_g + 3]), 64'hCA);
    check("den_rd_pulses", 64'(n_rd - base_rd), 64'd1);
    check("den_idle", 64'(busy), 64'd0);
    cnt_model = cnt_model + 1'b1;
    check("den_word_cnt", 64'(word_cnt), 64'(cnt_model));

    // Reset after 2 beats: outputs clear asynchronously, next word starts at beat 0
    base_g = got_d.size();
    en = 1'b1;
    wait_beats("rstm_timeout2", base_g + 2, 40);
    rst = 1'b1;
    #1;
    check("rstm_m_valid", 64'(bus.m_valid), 64'd0);
    check("rstm_busy", 64'(busy), 64'd0);
    check("rstm_m_last", 64'(bus.m_last), 64'd0);
    check("rstm_word_cnt", 64'(word_cnt), 64'd0);
    check("rstm_pre_b0", 64'(got_d[base_g + 0]), 64'hEF);
    check("rstm_pre_b1", 64'(got_d[base_g + 1]), 64'hBE);
    step(2);
    rst = 1'b0;
    cnt_model = '0;
    step(1);
    base_g = got_d.size();
    push(32'h0A0B0C0D);
    wait_beats("rstm_timeout4", base_g + 4, 40);
    step(3);
    check("rstm_beats", 64'(got_d.size() - base_g), 64'd4);
    check("rstm_b0", 64'(got_d[base_g + 0]), 64'h0D);
    check("rstm_b1", 64'(got_d[base_g + 1]), 64'h0C);
    check("rstm_b2", 64'(got_d[base_g + 2]), 64'h0B);
    check("rstm_b3", 64'(got_d[base_g + 3]), 64'h0A);
    check("rstm_last", 64'(got_l[base_g + 3]), 64'd1);
    cnt_model = cnt_model + 1'b1;
    check("rstm_word_cnt", 64'(word_cnt), 64'(cnt_model));

    // Randomized traffic: random pushes, en and m_ready
    base_g = got_d.size();
    base_st = stall_err;
    k = 0;
    while (got_d.size() < base_g + NW * BEATS && k < 5000) begin
      if (wq.size() < NW && $urandom_range(0, 2) == 0) begin
        w = $urandom;
        wq.push_back(w);
        push(w);
      end
      en = ($urandom_range(0, 7) != 0);
      bus.m_ready = ($urandom_range(0, 9) < 7);
      step(1);
      k++;
    end
    check("rand_timeout", 64'(got_d.size() >= base_g + NW * BEATS), 64'd1);
    bus.m_ready = 1'b1;
    en = 1'b0;
    step(4);
    for (int i = 0; i < wq.size(); i++) begin
      for (int j = 0; j < BEATS; j++) begin
        check("rand_beat", 64'(got_d[base_g + i * BEATS + j]), 64'((wq[i] >> (OW * j)) & 32'hFF));
        check("rand_last", 64'(got_l[base_g + i * BEATS + j]), 64'(j == BEATS - 1));
      end
    end
    cnt_model = cnt_model + CW'(wq.size());
    check("rand_word_cnt", 64'(word_cnt), 64'(cnt_model));
    check("rand_stall_hold", 64'(stall_err - base_st), 64'd0);
    check("rand_rd_while_empty", 64'(rd_empty_err), 64'd0);
    check("rand_idle", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
